// File: rtl/carry_chain_harness_if.sv
// Serial access bundle for the carry-chain harness: strobe, data in/out and status.
// The serial output is named dout_ser because `do` is a reserved word.
interface carry_chain_harness_if;
   logic stb;
   logic di;
   logic dout_ser;
   logic din_valid;
   logic err;

   modport master (output stb, output di, input dout_ser, input din_valid, input err);
   modport slave  (input stb, input di, output dout_ser, output din_valid, output err);
endinterface

// File: rtl/carry_chain_harness.sv
// Serial-in/serial-out harness around a vertical chain of CARRY8 cells, with
// a shift-bit counter, load-complete flag and sticky premature-strobe error.

// Behavioural CARRY8: ripple mux chain; DUAL mode splits the chain at bit 4.
module carry8_cell #(
   parameter bit DUAL = 1'b0
) (
   input  logic       ci,
   input  logic       ci_top,
   input  logic [7:0] s,
   input  logic [7:0] di,
   output logic [7:0] o,
   output logic [7:0] co
);
   always_comb begin
      logic carry;
      o     = '0;
      co    = '0;
      carry = ci;
      for (int i = 0; i < 8; i++) begin
         o[i]  = s[i] ^ carry;
         co[i] = s[i] ? carry : di[i];
         // CO[3] still reports the lower-half carry; the upper half restarts from CI_TOP
         carry = (DUAL && i == 3) ? ci_top : co[i];
      end
   end
endmodule

module carry_chain_harness #(
   parameter int          NUM_SLICES = 4,
   parameter logic [15:0] DUAL_MASK  = 16'h0000,
   parameter int          BASE_X     = 67,
   parameter int          BASE_Y     = 330,
   parameter int          DIN_N      = 16 * NUM_SLICES + 2,
   parameter int          DOUT_N     = 16 * NUM_SLICES
) (
   input logic                   clk,
   input logic                   rst,
   carry_chain_harness_if.slave  bus
);
   localparam int N8    = 8 * NUM_SLICES;
   localparam int CNT_W = $clog2(DIN_N + 1);

   if (NUM_SLICES < 1 || NUM_SLICES > 16) begin : g_bad_slices
      $error("carry_chain_harness: NUM_SLICES must be 1..16");
   end
   if (DIN_N < 16 * NUM_SLICES + 2) begin : g_bad_din
      $error("carry_chain_harness: DIN_N too small for the din field map");
   end
   if (DOUT_N < 16 * NUM_SLICES) begin : g_bad_dout
      $error("carry_chain_harness: DOUT_N too small for the dout field map");
   end
   if (BASE_X < 0 || BASE_Y < 0) begin : g_bad_loc
      $error("carry_chain_harness: slice coordinates must be non-negative");
   end

   // Builds "SLICE_X<x>Y<y>" as right-aligned ASCII for the placement attribute.
   function automatic logic [8*24-1:0] loc_name(input int x, input int y);
      logic [8*24-1:0] str;
      int              val;
      int              p;
      str = {136'd0, "SLICE_X"};
      for (int f = 0; f < 2; f++) begin
         val = (f == 0) ? x : y;
         if (f == 1) str = {str[8*23-1:0], "Y"};
         p = 1;
         while (p * 10 <= val) p = p * 10;
         while (p > 0) begin
            str = {str[8*23-1:0], 8'(48 + (val / p) % 10)};
            p   = p / 10;
         end
      end
      return str;
   endfunction

   logic [DIN_N-1:0]  din_shr_reg;
   logic [DIN_N-1:0]  din_reg;
   logic [DOUT_N-1:0] dout_shr_reg;
   logic [DOUT_N-1:0] dout_comb;
   logic [CNT_W-1:0]  shift_cnt_reg;
   logic [CNT_W-1:0]  shift_cnt_next;
   logic              din_valid_reg;
   logic              din_valid_next;
   logic              err_reg;

   genvar gi;
   for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      logic       ci_s;
      logic       ci_top_s;
      logic [7:0] o_s;
      logic [7:0] co_s;

      if (gi == 0) begin : g_head
         assign ci_s = din_reg[0];
      end else begin : g_link
         assign ci_s = g_slice[gi-1].co_s[7];
      end
      assign ci_top_s = DUAL_MASK[gi] ? din_reg[1 + 16 * NUM_SLICES] : 1'b0;

      (* DONT_TOUCH = "TRUE", LOC = loc_name(BASE_X, BASE_Y + gi) *)
      carry8_cell #(
         .DUAL (DUAL_MASK[gi])
      ) u_carry (
         .ci     (ci_s),
         .ci_top (ci_top_s),
         .s      (din_reg[1 + 8 * gi +: 8]),
         .di     (din_reg[1 + N8 + 8 * gi +: 8]),
         .o      (o_s),
         .co     (co_s)
      );

      assign dout_comb[8 * gi +: 8]      = o_s;
      assign dout_comb[N8 + 8 * gi +: 8] = co_s;
   end

   if (DOUT_N > 16 * NUM_SLICES) begin : g_dout_pad
      assign dout_comb[DOUT_N-1:16 * NUM_SLICES] = '0;
   end

   // Counter saturates at DIN_N so a long idle period never re-arms the error.
   always_comb begin
      shift_cnt_next = shift_cnt_reg;
      if (bus.stb) begin
         shift_cnt_next = '0;
      end else if (shift_cnt_reg != CNT_W'(DIN_N)) begin
         shift_cnt_next = shift_cnt_reg + 1'b1;
      end
      din_valid_next = (shift_cnt_next == CNT_W'(DIN_N));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_shr_reg   <= '0;
         din_reg       <= '0;
         dout_shr_reg  <= '0;
         shift_cnt_reg <= '0;
         din_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         din_shr_reg   <= {din_shr_reg[DIN_N-2:0], bus.di};
         shift_cnt_reg <= shift_cnt_next;
         din_valid_reg <= din_valid_next;
         if (bus.stb) begin
            din_reg      <= din_shr_reg;
            dout_shr_reg <= dout_comb;
            err_reg      <= err_reg | ~din_valid_reg;
         end else begin
            // Idle loopback: the harness echoes its serial input.
            dout_shr_reg <= {dout_shr_reg[DOUT_N-2:0], din_shr_reg[DIN_N-1]};
         end
      end
   end

   assign bus.dout_ser  = dout_shr_reg[DOUT_N-1];
   assign bus.din_valid = din_valid_reg;
   assign bus.err       = err_reg;
endmodule
